// File: rtl/clk_meas_pkg.sv
// rtl/clk_meas_pkg.sv - shared widths, timeout default and FSM states for the period meter
package clk_meas_pkg;

    localparam int DEF_W = 28;
    localparam logic [27:0] DEF_TIMEOUT = 28'd100_000_000;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        MEASURE = 2'd1,
        NOSIG   = 2'd2
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer with history flop and rise/fall detect
module edge_sync (
    input  logic clock_in,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall,
    output logic level
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;
    assign level = s2;

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures period and high time of sig_in in clock_in cycles
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int          W       = DEF_W,
    parameter logic [W-1:0] TIMEOUT = W'(DEF_TIMEOUT)
) (
    input  logic         clock_in,
    input  logic         reset,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         timeout
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] ONE     = W'(1);

    state_t       state;
    logic [W-1:0] cnt;
    logic [W-1:0] hcnt;
    logic [W-1:0] hold_high;
    logic         hi_phase;
    logic [W-1:0] cnt_next;
    logic [W-1:0] hcnt_next;
    logic         rise;
    logic         fall;
    logic         level;

    edge_sync u_sync (
        .clock_in (clock_in),
        .reset    (reset),
        .async_in (sig_in),
        .rise     (rise),
        .fall     (fall),
        .level    (level)
    );

    assign cnt_next  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign hcnt_next = (hcnt == CNT_MAX) ? hcnt : hcnt + 1'b1;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state     <= ARM;
            cnt       <= '0;
            hcnt      <= '0;
            hold_high <= '0;
            hi_phase  <= 1'b0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ARM: begin
                    if (rise) begin
                        cnt      <= ONE;
                        hcnt     <= ONE;
                        hi_phase <= 1'b1;
                        state    <= MEASURE;
                    end else begin
                        cnt <= cnt_next;
                        if (cnt == TIMEOUT) begin
                            state   <= NOSIG;
                            timeout <= 1'b1;
                        end
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period    <= cnt;
                        high_time <= hi_phase ? hcnt : hold_high;
                        valid     <= 1'b1;
                        cnt       <= ONE;
                        hcnt      <= ONE;
                        hi_phase  <= 1'b1;
                    end else begin
                        cnt <= cnt_next;
                        if (hi_phase && level) begin
                            hcnt <= hcnt_next;
                        end
                        if (fall) begin
                            hold_high <= hcnt;
                            hi_phase  <= 1'b0;
                        end
                        if (cnt == TIMEOUT) begin
                            state   <= NOSIG;
                            timeout <= 1'b1;
                        end
                    end
                end
                NOSIG: begin
                    if (rise) begin
                        timeout  <= 1'b0;
                        cnt      <= ONE;
                        hcnt     <= ONE;
                        hi_phase <= 1'b1;
                        state    <= MEASURE;
                    end
                end
                default: begin
                    state <= ARM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - directed self-checking bench with event-based reference model
module tb_clk_period_meter;

    localparam int W   = 28;
    localparam int TMO = 1000;

    logic         clock_in = 1'b0;
    logic         reset    = 1'b1;
    logic         sig_in   = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;

    clk_period_meter #(
        .W       (W),
        .TIMEOUT (W'(TMO))
    ) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout)
    );

    always #5 clock_in = ~clock_in;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int   cyc       = 0;
    int   r_idx     = 0;
    int   f_idx     = 0;
    bit   armed     = 0;
    bit   fall_seen = 0;
    bit   timed_out = 0;
    logic h1 = 1'b0;
    logic h2 = 1'b0;
    logic h3 = 1'b0;
    int   m_period  = 0;
    int   m_high    = 0;
    logic m_valid   = 1'b0;
    logic m_timeout = 1'b0;

    always @(posedge clock_in) begin
        cyc = cyc + 1;
        if (reset) begin
            h1 = 1'b0;
            h2 = 1'b0;
            h3 = 1'b0;
            armed     = 0;
            fall_seen = 0;
            timed_out = 0;
            r_idx     = cyc + 1;
            m_period  = 0;
            m_high    = 0;
            m_valid   = 1'b0;
            m_timeout = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (h2 && !h3) begin
                if (armed) begin
                    m_valid  = 1'b1;
                    m_period = cyc - r_idx;
                    m_high   = fall_seen ? (f_idx - r_idx) : (cyc - r_idx);
                end
                armed     = 1;
                timed_out = 0;
                m_timeout = 1'b0;
                fall_seen = 0;
                r_idx     = cyc;
            end else if (!timed_out) begin
                if (!h2 && h3 && armed && !fall_seen) begin
                    f_idx     = cyc;
                    fall_seen = 1;
                end
                if (cyc - r_idx == TMO) begin
                    timed_out = 1;
                    armed     = 0;
                    m_timeout = 1'b1;
                end
            end
            h3 = h2;
            h2 = h1;
            h1 = sig_in;
        end
    end

    int phase       = 0;
    int mon_phase   = 0;
    int vcount      = 0;
    int last_vcyc   = 0;
    int spacing     = 0;
    int to_rise_cyc = -1;
    bit saw_to      = 0;
    bit prev_to     = 0;

    always @(negedge clock_in) begin
        check("period_vs_model", 32'(period), 32'(m_period));
        check("high_vs_model", 32'(high_time), 32'(m_high));
        check("valid_vs_model", 32'(valid), 32'(m_valid));
        check("timeout_vs_model", 32'(timeout), 32'(m_timeout));
        if (phase != mon_phase) begin
            mon_phase = phase;
            vcount    = 0;
            saw_to    = 0;
        end
        if (valid === 1'b1) begin
            vcount++;
            spacing   = cyc - last_vcyc;
            last_vcyc = cyc;
        end
        if (timeout === 1'b1) begin
            saw_to = 1;
            if (!prev_to) to_rise_cyc = cyc;
        end
        prev_to = (timeout === 1'b1);
    end

    task automatic tick(input logic v);
        sig_in = v;
        @(posedge clock_in);
        #1;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi; i++) tick(1'b1);
            for (int i = 0; i < lo; i++) tick(1'b0);
        end
    endtask

    task automatic settle();
        @(negedge clock_in);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        reset = 1'b0;
        settle();
        check("reset_period", 32'(period), 32'd0);
        check("reset_high", 32'(high_time), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);

        phase = 1;
        wave(5, 5, 6);
        settle();
        check("f10_valid_count", 32'(vcount), 32'd5);
        check("f10_period", 32'(period), 32'd10);
        check("f10_high", 32'(high_time), 32'd5);
        check("f10_spacing", 32'(spacing), 32'd10);
        check("f10_model_period", 32'(m_period), 32'd10);

        phase = 2;
        wave(1, 1, 8);
        settle();
        check("f2_period", 32'(period), 32'd2);
        check("f2_high", 32'(high_time), 32'd1);
        check("f2_spacing", 32'(spacing), 32'd2);

        phase = 3;
        wave(3, 7, 4);
        settle();
        check("asym_period", 32'(period), 32'd10);
        check("asym_high", 32'(high_time), 32'd3);

        phase = 4;
        wave(5, 5, 3);
        wave(10, 10, 4);
        settle();
        check("f20_period", 32'(period), 32'd20);
        check("f20_high", 32'(high_time), 32'd10);

        phase = 5;
        wave(5, 5, 3);
        settle();
        phase = 6;
        for (int i = 0; i < 1100; i++) tick(1'b0);
        settle();
        check("idle_timeout", 32'(timeout), 32'd1);
        check("idle_valid_count", 32'(vcount), 32'd0);
        check("idle_period_hold", 32'(period), 32'd10);
        check("idle_high_hold", 32'(high_time), 32'd5);
        check("timeout_delay", 32'(to_rise_cyc - last_vcyc), 32'(TMO));

        phase = 7;
        wave(5, 5, 3);
        settle();
        check("resume_timeout", 32'(timeout), 32'd0);
        check("resume_valid_count", 32'(vcount), 32'd2);
        check("resume_period", 32'(period), 32'd10);

        phase = 8;
        for (int i = 0; i < 5; i++) tick(1'b1);
        tick(1'b0);
        reset = 1'b1;
        tick(1'b0);
        check("midreset_period", 32'(period), 32'd0);
        check("midreset_high", 32'(high_time), 32'd0);
        check("midreset_valid", 32'(valid), 32'd0);
        check("midreset_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;

        phase = 9;
        wave(5, 5, 3);
        settle();
        check("postreset_valid_count", 32'(vcount), 32'd2);
        check("postreset_period", 32'(period), 32'd10);
        check("postreset_high", 32'(high_time), 32'd5);

        phase = 10;
        for (int i = 0; i < 5; i++) tick(1'b1);
        for (int i = 0; i < TMO - 5; i++) tick(1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0);
        settle();
        check("edge_tmo_period", 32'(period), 32'(TMO));
        check("edge_tmo_high", 32'(high_time), 32'd5);
        check("edge_tmo_no_timeout", 32'(saw_to), 32'd0);
        check("edge_tmo_valid_count", 32'(vcount), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
